wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order writeback
//  path (wb_data_bus from wb_stage) and a long-latency unit (multiply/divide, MDU).
//  The pipeline has fixed priority. MDU results queue in a small FIFO and drain
//  in cycles where the pipeline does not write. A starvation counter raises a
//  stall request so queued MDU results always retire. Sits between wb_stage and the regfile.
// PARAMETERS
//  WB_DATA_BUS  38  width of packed writeback bus {rd[4:0], wen, data[31:0]}
//  FIFO_DEPTH   2   MDU result queue entries (power of 2, >=2)
//  STARVE_MAX   4   consecutive blocked cycles with FIFO non-empty before stall_req
// PORTS
//  clk             in   1            clock, all state on rising edge
//  rst_n           in   1            asynchronous active-low reset
//  wb_data_bus_in  in   WB_DATA_BUS  pipeline writeback {rd, wen, data}
//  mdu_valid       in   1            MDU result available
//  mdu_ready       out  1            queue can accept (= !full)
//  mdu_rd          in   5            MDU destination register
//  mdu_data        in   32           MDU result
//  rf_wb_bus_out   out  WB_DATA_BUS  registered write to regfile {rd, wen, data}
//  mdu_pend_mask   out  32           bit r set while a queued entry targets x[r]
//  stall_req       out  1            registered request to freeze the upstream pipeline
// BEHAVIOUR
//  - Reset: rf_wb_bus_out=0, stall_req=0, FIFO empty (mdu_ready=1), starve_cnt=0, mdu_pend_mask=0.
//  - pipe_hit = wen && rd!=0. Inputs with rd==0 are dropped and never written.
//  - MDU results with mdu_rd==0 are accepted (handshake completes) and discarded, not queued.
//  - Push when mdu_valid && mdu_ready && mdu_rd!=0. mdu_ready is !full only. There
//    is no push-while-full even when a pop happens in the same cycle.
//  - Pop when !pipe_hit && FIFO non-empty. The head goes to the output.
//  - A push and a pop in the same cycle are both performed (count unchanged).
//  - The FIFO has no bypass. An MDU result reaches rf_wb_bus_out no earlier than
//    2 cycles after its handshake.
//  - Output register, updated every cycle, 1-cycle latency:
//    pipe_hit -> {pipe rd, 1, pipe data}
//    else pop -> {head rd, 1, head data}
//    else {0, 0, 0}
//  - The pipeline is never back-pressured by data loss. pipe_hit always wins,
//    including while stall_req=1.
//  - starve_cnt (saturating):
//    cleared on a pop or when the FIFO is empty
//    incremented when pipe_hit blocks a non-empty FIFO
//  - stall_req: set at the next edge when starve_cnt reaches STARVE_MAX-1 while
//    blocked. Cleared at the edge after the first pop.
//  - mdu_pend_mask: OR of one-hot(rd) over valid FIFO entries, combinational from
//    FIFO state. Duplicate rd entries keep the bit set until the last of them pops.
//    The hazard unit uses this mask. WAW ordering against pipe writes is guaranteed
//    by issue logic, not checked here.
//  - Pointers are log2(FIFO_DEPTH) bits plus a wrap bit.
//    full  = pointers equal and wrap bits differ
//    empty = pointers and wrap bits equal
//  - Reset mid-operation: queued entries are lost, all outputs return to reset values asynchronously.
// TESTING
//  - Reset, then pipe {rd=5,wen=1,data=0xDEADBEEF} -> next cycle rf_wb_bus_out={5,1,0xDEADBEEF}.
//    Then rd=0,wen=1 -> output wen=0.
//  - Idle pipe, MDU {rd=7,data=0x12345678} handshake at cycle N.
//    Required: mdu_pend_mask[7]=1 at N+1; output {7,1,0x12345678} at N+2; mask[7]=0 after the pop.
//  - Pipe writes every cycle; push 2 MDU results.
//    Required: mdu_ready=0 when full; stall_req=1 after STARVE_MAX blocked cycles.
//    Then a pipe bubble: head pops, stall_req clears, second entry pops on the next bubble.
//  - Full FIFO with mdu_valid=1 and a pop in the same cycle: no push occurs.
//    The MDU value is held until mdu_ready=1, then accepted. FIFO order is preserved.
//  - Two MDU entries both rd=3: mask[3] stays 1 until the second pops.
//    An mdu_rd=0 result completes its handshake and never appears at the output.
//  - Assert rst_n low with 2 entries queued: outputs and mask are 0 immediately, mdu_ready=1.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has fixed priority, MDU
// results queue in a small FIFO and drain on pipeline bubbles, with a starvation stall.
module wb_port_arbiter #(
    parameter int unsigned WB_DATA_BUS = 38,
    parameter int unsigned FIFO_DEPTH  = 2,
    parameter int unsigned STARVE_MAX  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WB_DATA_BUS-1:0] wb_data_bus_in,
    input  logic                   mdu_valid,
    output logic                   mdu_ready,
    input  logic [4:0]             mdu_rd,
    input  logic [31:0]            mdu_data,
    output logic [WB_DATA_BUS-1:0] rf_wb_bus_out,
    output logic [31:0]            mdu_pend_mask,
    output logic                   stall_req
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PW1   = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [4:0]  pipe_rd;
    logic        pipe_wen;
    logic [31:0] pipe_data;
    logic        pipe_hit;

    logic [4:0]  fifo_rd   [FIFO_DEPTH];
    logic [31:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic [PTR_W:0] count;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           blocked;
    logic [CNT_W-1:0] starve_cnt;
    logic [PTR_W-1:0] slot;

    assign pipe_rd   = wb_data_bus_in[WB_DATA_BUS-1 -: 5];
    assign pipe_wen  = wb_data_bus_in[32];
    assign pipe_data = wb_data_bus_in[31:0];
    assign pipe_hit  = pipe_wen && (pipe_rd != 5'd0);

    assign full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;

    assign mdu_ready = !full;
    // rd==0 results complete the handshake but are never stored
    assign push    = mdu_valid && !full && (mdu_rd != 5'd0);
    assign pop     = !pipe_hit && !empty;
    assign blocked = pipe_hit && !empty;

    // Pending-destination mask over the occupied FIFO slots
    always_comb begin
        mdu_pend_mask = '0;
        slot          = '0;
        for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
            slot = rd_ptr[PTR_W-1:0] + PTR_W'(k);
            if (PW1'(k) < count) begin
                mdu_pend_mask[fifo_rd[slot]] = 1'b1;
            end
        end
    end

    // Queue storage needs no reset: occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr[PTR_W-1:0]]   <= mdu_rd;
            fifo_data[wr_ptr[PTR_W-1:0]] <= mdu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            starve_cnt    <= '0;
            stall_req     <= 1'b0;
            rf_wb_bus_out <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW1'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW1'(1);
            end

            if (pipe_hit) begin
                rf_wb_bus_out <= {pipe_rd, 1'b1, pipe_data};
            end else if (pop) begin
                rf_wb_bus_out <= {fifo_rd[rd_ptr[PTR_W-1:0]], 1'b1, fifo_data[rd_ptr[PTR_W-1:0]]};
            end else begin
                rf_wb_bus_out <= '0;
            end

            if (pop || empty) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end

            if (blocked && (starve_cnt >= CNT_W'(STARVE_MAX - 1))) begin
                stall_req <= 1'b1;
            end else if (pop) begin
                stall_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, reset corner
// sequence, and randomized traffic against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int unsigned W  = 38;
    localparam int unsigned D  = 2;
    localparam int unsigned SM = 4;
    localparam int unsigned NV = 19;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  bus_in;
    logic          mv;
    logic          mready;
    logic [4:0]    mrd;
    logic [31:0]   mdata;
    logic [W-1:0]  rf_out;
    logic [31:0]   pmask;
    logic          stall;

    always #5 clk = ~clk;

    wb_port_arbiter #(.WB_DATA_BUS(W), .FIFO_DEPTH(D), .STARVE_MAX(SM)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wb_data_bus_in (bus_in),
        .mdu_valid      (mv),
        .mdu_ready      (mready),
        .mdu_rd         (mrd),
        .mdu_data       (mdata),
        .rf_wb_bus_out  (rf_out),
        .mdu_pend_mask  (pmask),
        .stall_req      (stall)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] wb(input logic [4:0] rd, input logic w, input logic [31:0] dt);
        return {rd, w, dt};
    endfunction

    // Reference model: a queue of {rd, data} plus a starvation counter
    logic [36:0] mq[$];
    int          m_starve;
    logic        m_stall;
    logic [W-1:0] m_out;

    function automatic logic [31:0] m_mask();
        logic [31:0] m = '0;
        foreach (mq[i]) m[mq[i][36:32]] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_starve = 0;
        m_stall  = 1'b0;
        m_out    = '0;
    endtask

    task automatic model_step(input logic [W-1:0] b, input logic v, input logic [4:0] r, input logic [31:0] d);
        logic hit;
        logic acc;
        logic popped;
        logic blk;
        hit    = b[32] && (b[37:33] != 5'd0);
        acc    = v && (mq.size() < D);
        popped = !hit && (mq.size() > 0);
        blk    = hit && (mq.size() > 0);
        if (hit)         m_out = b;
        else if (popped) m_out = {mq[0][36:32], 1'b1, mq[0][31:0]};
        else             m_out = '0;
        if (blk && m_starve >= SM - 1) m_stall = 1'b1;
        else if (popped)               m_stall = 1'b0;
        if (popped || mq.size() == 0) m_starve = 0;
        else if (blk && m_starve < SM) m_starve = m_starve + 1;
        if (popped) void'(mq.pop_front());
        if (acc && r != 5'd0) mq.push_back({r, d});
    endtask

    // One clock: drive, check pre-edge state, advance, check registered results
    task automatic step(input logic [W-1:0] b, input logic v, input logic [4:0] r, input logic [31:0] d);
        bus_in = b; mv = v; mrd = r; mdata = d;
        #1;
        chk("ready_pre", {63'd0, mready}, {63'd0, mq.size() < D});
        chk("mask_pre", {32'd0, pmask}, {32'd0, m_mask()});
        model_step(b, v, r, d);
        @(posedge clk);
        #1;
        chk("out", {26'd0, rf_out}, {26'd0, m_out});
        chk("stall", {63'd0, stall}, {63'd0, m_stall});
        chk("ready", {63'd0, mready}, {63'd0, mq.size() < D});
        chk("mask", {32'd0, pmask}, {32'd0, m_mask()});
    endtask

    typedef struct {
        logic [W-1:0] bus;
        logic         v;
        logic [4:0]   r;
        logic [31:0]  d;
        logic [W-1:0] eo;
        logic         er;
        logic         es;
        logic [31:0]  em;
    } vec_t;

    vec_t tbl[NV];

    task automatic setv(input int i, input logic [W-1:0] b, input logic v, input logic [4:0] r,
                        input logic [31:0] d, input logic [W-1:0] eo, input logic er,
                        input logic es, input logic [31:0] em);
        tbl[i].bus = b; tbl[i].v = v; tbl[i].r = r; tbl[i].d = d;
        tbl[i].eo = eo; tbl[i].er = er; tbl[i].es = es; tbl[i].em = em;
    endtask

    initial begin
        logic [W-1:0] z;
        z = '0;
        // pipe write, then rd=0 dropped
        setv(0,  wb(5'd5, 1'b1, 32'hDEADBEEF), 1'b0, 5'd0,  32'h0, wb(5'd5, 1'b1, 32'hDEADBEEF), 1'b1, 1'b0, 32'h0);
        setv(1,  wb(5'd0, 1'b1, 32'h11111111), 1'b0, 5'd0,  32'h0, z, 1'b1, 1'b0, 32'h0);
        // MDU on idle pipe: mask at N+1, output at N+2
        setv(2,  z, 1'b1, 5'd7,  32'h12345678, z, 1'b1, 1'b0, 32'h0000_0080);
        setv(3,  z, 1'b0, 5'd0,  32'h0, wb(5'd7, 1'b1, 32'h12345678), 1'b1, 1'b0, 32'h0);
        setv(4,  z, 1'b0, 5'd0,  32'h0, z, 1'b1, 1'b0, 32'h0);
        // starvation: pipe writes every cycle while two results queue
        setv(5,  wb(5'd1, 1'b1, 32'hA0), 1'b1, 5'd9,  32'h99, wb(5'd1, 1'b1, 32'hA0), 1'b1, 1'b0, 32'h0000_0200);
        setv(6,  wb(5'd1, 1'b1, 32'hA1), 1'b1, 5'd10, 32'hAA, wb(5'd1, 1'b1, 32'hA1), 1'b0, 1'b0, 32'h0000_0600);
        setv(7,  wb(5'd1, 1'b1, 32'hA2), 1'b1, 5'd11, 32'hBB, wb(5'd1, 1'b1, 32'hA2), 1'b0, 1'b0, 32'h0000_0600);
        setv(8,  wb(5'd1, 1'b1, 32'hA3), 1'b1, 5'd11, 32'hBB, wb(5'd1, 1'b1, 32'hA3), 1'b0, 1'b0, 32'h0000_0600);
        setv(9,  wb(5'd1, 1'b1, 32'hA4), 1'b1, 5'd11, 32'hBB, wb(5'd1, 1'b1, 32'hA4), 1'b0, 1'b1, 32'h0000_0600);
        // bubble pops head while full: no push this cycle, stall clears
        setv(10, z, 1'b1, 5'd11, 32'hBB, wb(5'd9, 1'b1, 32'h99), 1'b1, 1'b0, 32'h0000_0400);
        setv(11, wb(5'd1, 1'b1, 32'hA5), 1'b1, 5'd11, 32'hBB, wb(5'd1, 1'b1, 32'hA5), 1'b0, 1'b0, 32'h0000_0C00);
        setv(12, z, 1'b0, 5'd0,  32'h0, wb(5'd10, 1'b1, 32'hAA), 1'b1, 1'b0, 32'h0000_0800);
        setv(13, z, 1'b0, 5'd0,  32'h0, wb(5'd11, 1'b1, 32'hBB), 1'b1, 1'b0, 32'h0);
        // duplicate rd=3 entries, then an rd=0 result that is discarded
        setv(14, wb(5'd1, 1'b1, 32'hC0), 1'b1, 5'd3, 32'h31, wb(5'd1, 1'b1, 32'hC0), 1'b1, 1'b0, 32'h0000_0008);
        setv(15, wb(5'd1, 1'b1, 32'hC1), 1'b1, 5'd3, 32'h32, wb(5'd1, 1'b1, 32'hC1), 1'b0, 1'b0, 32'h0000_0008);
        setv(16, z, 1'b0, 5'd0, 32'h0,   wb(5'd3, 1'b1, 32'h31), 1'b1, 1'b0, 32'h0000_0008);
        setv(17, z, 1'b1, 5'd0, 32'hBAD, wb(5'd3, 1'b1, 32'h32), 1'b1, 1'b0, 32'h0);
        setv(18, z, 1'b0, 5'd0, 32'h0,   z, 1'b1, 1'b0, 32'h0);

        rst_n = 1'b0; bus_in = '0; mv = 1'b0; mrd = '0; mdata = '0;
        model_reset();
        #17;
        chk("reset_out", {26'd0, rf_out}, 64'd0);
        chk("reset_ready", {63'd0, mready}, 64'd1);
        chk("reset_mask", {32'd0, pmask}, 64'd0);
        chk("reset_stall", {63'd0, stall}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            step(tbl[i].bus, tbl[i].v, tbl[i].r, tbl[i].d);
            chk($sformatf("vec%0d_out", i), {26'd0, rf_out}, {26'd0, tbl[i].eo});
            chk($sformatf("vec%0d_ready", i), {63'd0, mready}, {63'd0, tbl[i].er});
            chk($sformatf("vec%0d_stall", i), {63'd0, stall}, {63'd0, tbl[i].es});
            chk($sformatf("vec%0d_mask", i), {32'd0, pmask}, {32'd0, tbl[i].em});
        end

        // Queue two entries under pipe pressure until stall, then reset mid-cycle
        step(wb(5'd2, 1'b1, 32'h1), 1'b1, 5'd4, 32'h44);
        step(wb(5'd2, 1'b1, 32'h2), 1'b1, 5'd6, 32'h66);
        for (int i = 0; i < 4; i++) step(wb(5'd2, 1'b1, 32'h10 + 32'(i)), 1'b0, 5'd0, 32'h0);
        chk("pre_rst_stall", {63'd0, stall}, 64'd1);
        chk("pre_rst_mask", {32'd0, pmask}, 64'h50);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", {26'd0, rf_out}, 64'd0);
        chk("mid_rst_stall", {63'd0, stall}, 64'd0);
        chk("mid_rst_mask", {32'd0, pmask}, 64'd0);
        chk("mid_rst_ready", {63'd0, mready}, 64'd1);
        bus_in = '0; mv = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        step('0, 1'b0, 5'd0, 32'h0);

        // Randomized traffic, alternating light and heavy pipeline load
        for (int i = 0; i < 600; i++) begin
            int unsigned pct;
            logic [W-1:0] b;
            pct = ((i / 40) % 2 == 1) ? 92 : 45;
            b = wb(5'($urandom_range(0, 7)), $urandom_range(0, 99) < pct, $urandom);
            step(b, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
